// File: rtl/fetch_pc_unit.sv
// Fetch PC and IF/ID register with single branch delay slot; redirects are resolved in ID.
// Optional per-branch statistics counters are enabled by defining BRANCH_STAT_EN.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          ADDR_W   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] F_instr,
    input  logic        equal,
    input  logic [2:0]  br_type,
    input  logic [15:0] imm16,
    input  logic [25:0] index26,
    input  logic [31:0] jr_target,
    output logic [31:0] F_pc,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc,
    output logic [31:0] D_pc8,
`ifdef BRANCH_STAT_EN
    output logic [31:0] br_cnt,
    output logic [31:0] taken_cnt,
`endif
    output logic        br_taken
);

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_J    = 3'd3;
    localparam logic [2:0] BR_JR   = 3'd4;

    generate
        if (ADDR_W != 32) begin : g_bad_addr_w
            $error("fetch_pc_unit: ADDR_W must be 32");
        end
    endgenerate

    logic [31:0] f_pc_reg;
    logic [31:0] d_instr_reg;
    logic [31:0] d_pc_reg;
    logic [31:0] pc_next;
    logic [31:0] d_pc_plus4;
    logic [31:0] br_offset;
    logic        taken_raw;

    assign d_pc_plus4 = d_pc_reg + 32'd4;
    assign br_offset  = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        taken_raw = 1'b0;
        case (br_type)
            BR_BEQ:  taken_raw = equal;
            BR_BNE:  taken_raw = !equal;
            BR_J:    taken_raw = 1'b1;
            BR_JR:   taken_raw = 1'b1;
            default: taken_raw = 1'b0;
        endcase
    end

    // A stalled branch must not redirect; it re-resolves once operands are fresh.
    assign br_taken = taken_raw && !stall;

    always_comb begin
        pc_next = f_pc_reg + 32'd4;
        if (taken_raw) begin
            case (br_type)
                BR_BEQ, BR_BNE: pc_next = d_pc_plus4 + br_offset;
                BR_J:           pc_next = {d_pc_plus4[31:28], index26, 2'b00};
                BR_JR:          pc_next = jr_target & 32'hFFFF_FFFC;
                default:        pc_next = f_pc_reg + 32'd4;
            endcase
        end
    end

    // No flush on redirect: the delay-slot instruction in IF always moves into ID.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_pc_reg    <= RESET_PC;
            d_instr_reg <= 32'd0;
            d_pc_reg    <= RESET_PC;
        end else if (!stall) begin
            f_pc_reg    <= pc_next;
            d_instr_reg <= F_instr;
            d_pc_reg    <= f_pc_reg;
        end
    end

    assign F_pc    = f_pc_reg;
    assign D_instr = d_instr_reg;
    assign D_pc    = d_pc_reg;
    assign D_pc8   = d_pc_reg + 32'd8;

`ifdef BRANCH_STAT_EN
    logic [1:0] cnt_inc;
    assign cnt_inc[0] = !stall && (br_type != BR_NONE) && (br_type <= BR_JR);
    assign cnt_inc[1] = br_taken;

    // Index 0 counts resolved branches, index 1 counts taken ones; both saturate.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [31:0] cnt_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_reg <= 32'd0;
                end else if (cnt_inc[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
        end
    endgenerate

    assign br_cnt    = g_cnt[0].cnt_reg;
    assign taken_cnt = g_cnt[1].cnt_reg;
`endif

endmodule
